multdiv_unit: RTL and testbench

Iterative signed 32-bit multiply/divide unit in the execute stage, downstream of decode and alongside the ALU. It is the main consumer of the team's 32-bit CLA adder, procAdder: one procAdder instance performs every add/subtract step. It accepts a one-cycle start pulse and returns a registered result with a one-cycle ready pulse. The pipeline stall logic sees a fixed 33-cycle latency for both operations.

---
 rtl/multdiv_pkg.sv | 11 +
 rtl/multdiv_ctrl.sv | 59 +++++
 rtl/procAdder.sv | 48 ++++
 rtl/multdiv_unit.sv | 145 ++++++++++++++
 tb/tb_multdiv_unit.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   localparam int unsigned ITER_COUNT = 32;
   localparam int unsigned CNT_W      = 6;
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(ITER_COUNT);
   localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/multdiv_ctrl.sv
// Sequencer: start arbitration (MULT over DIV), 33-cycle iteration count, ready pulse.
module multdiv_ctrl
   import multdiv_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   mult_i,
   input  logic   div_i,
   output state_t state_o,
   output logic   start_mul_o,
   output logic   start_div_o,
   output logic   iter_o,
   output logic   finish_o,
   output logic   rdy_o
);
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             rdy_q;
   logic             busy;

   assign start_mul_o = mult_i;
   assign start_div_o = div_i & ~mult_i;
   assign busy        = (state_q == MUL) || (state_q == DIV);
   assign iter_o      = busy && (cnt_q < CNT_TERM) && !mult_i && !div_i;
   assign finish_o    = busy && (cnt_q == CNT_TERM) && !mult_i && !div_i;
   assign state_o     = state_q;
   assign rdy_o       = rdy_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         rdy_q <= 1'b0;
         if (mult_i) begin
            state_q <= MUL;
            cnt_q   <= '0;
         end else if (div_i) begin
            state_q <= DIV;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               MUL, DIV: begin
                  // counter saturates at terminal count; that cycle completes
                  if (cnt_q < CNT_TERM) begin
                     cnt_q <= cnt_q + 1'b1;
                  end else begin
                     state_q <= DONE;
                     rdy_q   <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/procAdder.sv
// 32-bit carry-lookahead adder: 4-bit groups with group generate/propagate.
module procAdder (
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        c_in,
   output logic [31:0] data_sum,
   output logic        c_out,
   output logic        overflow
);
   logic [31:0] g, p;
   logic [7:0]  bg, bp;
   logic        blk_c, bit_c, c_msb;

   assign g = data_operandA & data_operandB;
   assign p = data_operandA ^ data_operandB;

   always_comb begin
      bg = '0;
      bp = '0;
      for (int unsigned blk = 0; blk < 8; blk++) begin
         bg[blk] = g[blk*4+3]
                 | (p[blk*4+3] & g[blk*4+2])
                 | (p[blk*4+3] & p[blk*4+2] & g[blk*4+1])
                 | ((&p[blk*4+1 +: 3]) & g[blk*4]);
         bp[blk] = &p[blk*4 +: 4];
      end
   end

   always_comb begin
      blk_c    = c_in;
      bit_c    = 1'b0;
      c_msb    = 1'b0;
      data_sum = '0;
      for (int unsigned blk = 0; blk < 8; blk++) begin
         for (int unsigned i = 0; i < 4; i++) begin
            bit_c = blk_c;
            for (int unsigned k = 0; k < i; k++)
               bit_c = g[blk*4+k] | (p[blk*4+k] & bit_c);
            data_sum[blk*4+i] = p[blk*4+i] ^ bit_c;
            if (blk*4+i == 31) c_msb = bit_c;
         end
         blk_c = bg[blk] | (bp[blk] & blk_c);
      end
      c_out    = blk_c;
      overflow = c_msb ^ blk_c;
   end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (non-restoring),
// fixed 33-cycle latency, every add/subtract through one procAdder.
module multdiv_unit
   import multdiv_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY
);
   state_t state;
   logic   start_mul, start_div, start, iter, finish;

   logic [32:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d, opnd_q, opnd_d, res_q, res_d;
   logic        qm1_q, qm1_d, neg_q, neg_d, zero_q, zero_d, dovf_q, dovf_d, exc_q, exc_d;

   logic [31:0] add_a, add_b, sum;
   logic        add_cin, cout, ovf, booth_sub, div_inv;
   logic [32:0] shl_r, booth_hi, r_next, upper;

   multdiv_ctrl u_ctrl (
      .clk_i       (clock),
      .rst_i       (reset),
      .mult_i      (ctrl_MULT),
      .div_i       (ctrl_DIV),
      .state_o     (state),
      .start_mul_o (start_mul),
      .start_div_o (start_div),
      .iter_o      (iter),
      .finish_o    (finish),
      .rdy_o       (data_resultRDY)
   );

   procAdder u_add (
      .data_operandA (add_a),
      .data_operandB (add_b),
      .c_in          (add_cin),
      .data_sum      (sum),
      .c_out         (cout),
      .overflow      (ovf)
   );

   assign start     = start_mul | start_div;
   assign booth_sub = lo_q[0] & ~qm1_q;
   // subtract |B| while remainder >= 0; a negative divisor flips add/sub so |B| is never formed
   assign div_inv   = ~hi_q[32] ^ opnd_q[31];
   assign shl_r     = {hi_q[31:0], lo_q[31]};
   assign upper     = {hi_q[31:0], lo_q[31]};

   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (start) begin
         add_b   = ~data_operandA;
         add_cin = 1'b1;
      end else if (finish) begin
         add_b   = ~lo_q;
         add_cin = 1'b1;
      end else if (state == MUL) begin
         add_a   = hi_q[31:0];
         add_b   = booth_sub ? ~opnd_q : opnd_q;
         add_cin = booth_sub;
      end else begin
         add_a   = shl_r[31:0];
         add_b   = div_inv ? ~opnd_q : opnd_q;
         add_cin = div_inv;
      end
   end

   always_comb begin
      hi_d     = hi_q;
      lo_d     = lo_q;
      qm1_d    = qm1_q;
      opnd_d   = opnd_q;
      neg_d    = neg_q;
      zero_d   = zero_q;
      dovf_d   = dovf_q;
      res_d    = res_q;
      exc_d    = exc_q;
      booth_hi = '0;
      r_next   = '0;
      if (start) begin
         opnd_d = start_mul ? data_operandA : data_operandB;
         hi_d   = '0;
         qm1_d  = 1'b0;
         lo_d   = start_mul ? data_operandB : (data_operandA[31] ? sum : data_operandA);
         neg_d  = data_operandA[31] ^ data_operandB[31];
         zero_d = (data_operandB == '0);
         dovf_d = (data_operandA == INT_MIN) && (data_operandB == '1);
      end else if (iter && state == MUL) begin
         booth_hi = (lo_q[0] ^ qm1_q) ? {sum[31] ^ ovf, sum} : {hi_q[31], hi_q[31:0]};
         {hi_d, lo_d, qm1_d} = {booth_hi[32], booth_hi, lo_q};
      end else if (iter) begin
         r_next = {shl_r[32] ^ add_b[31] ^ cout, sum};
         hi_d   = r_next;
         lo_d   = {lo_q[30:0], ~r_next[32]};
      end else if (finish) begin
         if (state == MUL) begin
            res_d = lo_q;
            exc_d = ~((&upper) | ~(|upper));
         end else if (zero_q) begin
            res_d = '0;
            exc_d = 1'b1;
         end else begin
            res_d = neg_q ? sum : lo_q;
            exc_d = dovf_q;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hi_q   <= '0;
         lo_q   <= '0;
         qm1_q  <= 1'b0;
         opnd_q <= '0;
         neg_q  <= 1'b0;
         zero_q <= 1'b0;
         dovf_q <= 1'b0;
         res_q  <= '0;
         exc_q  <= 1'b0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         qm1_q  <= qm1_d;
         opnd_q <= opnd_d;
         neg_q  <= neg_d;
         zero_q <= zero_d;
         dovf_q <= dovf_d;
         res_q  <= res_d;
         exc_q  <= exc_d;
      end
   end

   assign data_result    = res_q;
   assign data_exception = exc_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed cases plus random ops vs an arithmetic model.
module tb_multdiv_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   int unsigned errors = 0;
   int unsigned checks = 0;

   multdiv_unit dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Returns {exception, result} from plain signed arithmetic.
   function automatic logic [32:0] model(input bit mul, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, r, lim;
      sa  = longint'(signed'(a));
      sb  = longint'(signed'(b));
      lim = 64'sd2147483648;
      if (mul) begin
         r = sa * sb;
         return {(r < -lim) || (r >= lim), r[31:0]};
      end
      if (b == 32'h0) return {1'b1, 32'h0};
      if (sa == -lim && sb == -64'sd1) return {1'b1, 32'h8000_0000};
      r = sa / sb;
      return {1'b0, r[31:0]};
   endfunction

   // Start pulse sampled at the next rising edge (edge 0); operands scrambled afterwards.
   task automatic start_op(input bit mul, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = mul;
      ctrl_DIV      = !mul;
      @(posedge clock);
      #1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   task automatic wait_result(input string tag, input logic [31:0] exp_res, input logic exp_exc);
      int unsigned early;
      early = 0;
      for (int i = 1; i <= 32; i++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) early++;
      end
      check({tag, "_rdy_early"}, early, 32'd0);
      @(posedge clock);
      #1;
      check({tag, "_rdy33"}, {31'd0, data_resultRDY}, 32'd1);
      check({tag, "_res"}, data_result, exp_res);
      check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
   endtask

   task automatic run_op(input string tag, input bit mul, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_exc);
      start_op(mul, a, b);
      wait_result(tag, exp_res, exp_exc);
   endtask

   initial begin
      logic [32:0] exp;
      logic [31:0] ra, rb;
      bit          rmul;
      int unsigned cnt;

      repeat (3) @(posedge clock);
      #1;
      check("rst_res", data_result, 32'h0);
      check("rst_exc", {31'd0, data_exception}, 32'd0);
      check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      run_op("mul_7x-3", 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
      @(posedge clock);
      #1;
      check("rdy_fall34", {31'd0, data_resultRDY}, 32'd0);
      check("res_hold34", data_result, 32'hFFFF_FFEB);

      run_op("mul_ovf16", 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
      run_op("mul_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      run_op("div_-7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
      run_op("div_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 1'b0);
      run_op("div_by0", 1'b0, 32'd5, 32'd0, 32'h0, 1'b1);
      run_op("div_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      run_op("div_min_1", 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
      run_op("div_7_-min", 1'b0, 32'd7, 32'h8000_0000, 32'h0, 1'b0);

      // Abort: DIV at edge 0, MULT at edge 10; only the MULT completes (edge 43).
      start_op(1'b0, 32'd100, 32'd7);
      cnt = 0;
      for (int i = 1; i <= 9; i++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) cnt++;
      end
      check("abort_rdy_pre", cnt, 32'd0);
      run_op("abort_mul6x7", 1'b1, 32'd6, 32'd7, 32'd42, 1'b0);

      // Reset at edge 20 of a MULT.
      start_op(1'b1, 32'd1234, 32'd5678);
      repeat (19) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("midrst_res", data_result, 32'h0);
      check("midrst_exc", {31'd0, data_exception}, 32'd0);
      check("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) cnt++;
      end
      check("midrst_no_rdy", cnt, 32'd0);
      run_op("mul_3x3", 1'b1, 32'd3, 32'd3, 32'd9, 1'b0);

      // Random back-to-back ops (each start lands in the previous RDY cycle).
      for (int n = 0; n < 24; n++) begin
         rmul = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0: begin ra = $urandom; rb = $urandom; end
            1: begin ra = 32'($urandom_range(0, 200)) - 32'd100; rb = 32'($urandom_range(0, 200)) - 32'd100; end
            2: begin ra = $urandom; rb = 32'($urandom_range(0, 20)) - 32'd10; end
            default: begin ra = $urandom >> $urandom_range(0, 31); rb = $urandom >> $urandom_range(0, 31); end
         endcase
         exp = model(rmul, ra, rb);
         run_op($sformatf("rand%0d_%s", n, rmul ? "mul" : "div"), rmul, ra, rb, exp[31:0], exp[32]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
